// File: rtl/conv33_stencil_sched.sv
// conv33_stencil_sched: frame scheduler for the 3x3 line-buffer convolution datapath.
// Tracks the (col,row) of the pixel in the stage register, gates the input-register and
// line-buffer enables, and qualifies adder results with out_valid for full 3x3 windows.
// Optional feature: define CONV33_SCHED_PERF_EN to add the stall_cycles counter port.
module conv33_stencil_sched #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in_reg_en,
  output logic             buf_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row
`ifdef CONV33_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] ColMax = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] RowMax = CNT_W'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             s_vld_q, s_vld_d;
  logic             first_q, first_d;           // next accept is pixel (0,0)
  logic             last_taken_q, last_taken_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;

  logic             win, advance, accept, stage_last, in_last;
  logic [CNT_W-1:0] in_col, in_row;

  // Handshake, window qualification and label of the incoming pixel
  always_comb begin
    win        = (col_q >= CNT_W'(2)) && (row_q >= CNT_W'(2));
    advance    = s_vld_q && (!win || out_ready);
    in_ready   = (state_q == StRun) && !last_taken_q && (!s_vld_q || advance);
    accept     = in_valid && in_ready;
    stage_last = (col_q == ColMax) && (row_q == RowMax);
    in_col     = '0;
    in_row     = '0;
    if (!first_q) begin
      if (col_q == ColMax) begin
        in_col = '0;
        in_row = row_q + CNT_W'(1);
      end else begin
        in_col = col_q + CNT_W'(1);
        in_row = row_q;
      end
    end
    in_last = (in_col == ColMax) && (in_row == RowMax);
  end

  // Next-state for FSM, stage valid and position counters
  always_comb begin
    state_d      = state_q;
    s_vld_d      = s_vld_q;
    first_d      = first_q;
    last_taken_d = last_taken_q;
    col_d        = col_q;
    row_d        = row_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          s_vld_d      = 1'b0;
          first_d      = 1'b1;
          last_taken_d = 1'b0;
          col_d        = '0;
          row_d        = '0;
        end
      end
      StRun: begin
        s_vld_d = accept || (s_vld_q && !advance);
        if (accept) begin
          col_d   = in_col;
          row_d   = in_row;
          first_d = 1'b0;
          if (in_last) last_taken_d = 1'b1;
        end
        if (advance && stage_last && last_taken_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      s_vld_q      <= 1'b0;
      first_q      <= 1'b0;
      last_taken_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      s_vld_q      <= s_vld_d;
      first_q      <= first_d;
      last_taken_q <= last_taken_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  // Datapath enables and status outputs
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    in_reg_en = accept;
    buf_en    = advance;
    out_valid = s_vld_q && win;
    out_last  = out_valid && stage_last;
    col       = col_q;
    row       = row_q;
  end

`ifdef CONV33_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles a result waits on downstream
  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && start) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv33_stencil_sched.sv
// Self-checking bench for conv33_stencil_sched on a 4x4 frame. The reference model tracks
// only pixel counts (accepted / retired) and derives each pixel's raster position and
// window membership arithmetically.
module tb_conv33_stencil_sched;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 16;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, in_ready, in_reg_en, buf_en, out_valid, out_last;
  logic [CW-1:0] col, row;
`ifdef CONV33_SCHED_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  conv33_stencil_sched #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg_en (in_reg_en),
    .buf_en    (buf_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .col       (col),
    .row       (row)
`ifdef CONV33_SCHED_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_in_reg_en"}, in_reg_en, 0);
    chk({tag, "_buf_en"}, buf_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_row"}, row, 0);
`ifdef CONV33_SCHED_PERF_EN
    chk({tag, "_stall"}, stall_cycles, 0);
`endif
  endtask

  // Modes: 0 full rate, 1 five-cycle stall at first window, 2 in_valid toggling,
  // 3 random valid/ready, 4 extra start pulse mid-frame. rst_at >= 0 aborts the frame
  // with a reset once that many pixels were accepted.
  // Entered and left at posedge+1.
  task automatic run_frame(input int mode, input int rst_at);
    int  acc = 0, ret = 0, wins = 0, stalls = 0, cyc = 0, hold = 0;
    bit  stalled_once = 0, done_exp = 0, finished = 0;
    bit  occ, w, e_adv, e_rdy;
    int  pix;
    while (!finished && cyc < 500) begin
      // drive inputs for this cycle
      start    = (cyc == 0) || (mode == 4 && cyc == 6);
      in_valid = (mode == 2) ? cyc[0] : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      pix = ret;
      occ = acc > ret;
      w   = occ && (pix % W >= 2) && (pix / W >= 2);
      if (mode == 1 && !stalled_once && w) begin
        hold = 5;
        stalled_once = 1;
      end
      if (mode == 3) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = (hold == 0);
      if (hold > 0) hold--;
      @(negedge clk);
      e_adv = occ && (!w || out_ready);
      e_rdy = (cyc >= 1) && (acc < NPIX) && (!occ || e_adv);
      chk("out_valid", out_valid, w);
      chk("out_last", out_last, w && (pix == NPIX - 1));
      chk("buf_en", buf_en, e_adv);
      chk("in_ready", in_ready, e_rdy);
      chk("in_reg_en", in_reg_en, in_valid && e_rdy);
      chk("done", done, done_exp);
      chk("busy", busy, cyc >= 1);
      if (occ) begin
        chk("col", col, pix % W);
        chk("row", row, pix / W);
      end
      if (w && !out_ready) stalls++;
      if (w && out_ready) wins++;
      if (done_exp) finished = 1;
      done_exp = e_adv && (pix == NPIX - 1);
      if (in_valid && e_rdy) acc++;
      if (e_adv) ret++;
      if (rst_at >= 0 && acc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (!finished) chk("frame_timeout", 1, 0);
    chk("busy_after_done", busy, 0);
    chk("accepts", acc, NPIX);
    chk("retires", ret, NPIX);
    chk("windows", wins, (W - 2) * (H - 2));
    if (mode == 1) chk("stall_len", stalls, 5);
`ifdef CONV33_SCHED_PERF_EN
    chk("stall_cycles", stall_cycles, stalls);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("idle");
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(0, 7);
    run_frame(0, -1);
    run_frame(4, -1);
    run_frame(0, -1);
    for (int i = 0; i < 6; i++) run_frame(3, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
